// File: rtl/fetch_stage_if.sv
// Bundle of the fetch stage's memory, redirect and IF/ID signals.
// master = fetch stage side, slave = memory / pipeline environment side.
interface fetch_stage_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        id_stall;
    logic        id_valid;
    logic [15:0] id_instr;
    logic [15:0] id_pc;
    logic [15:0] id_pc_inc;
    logic        err;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        input  redirect_valid, redirect_pc, id_stall,
        output id_valid, id_instr, id_pc, id_pc_inc, err
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        output redirect_valid, redirect_pc, id_stall,
        input  id_valid, id_instr, id_pc, id_pc_inc, err
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: PC / next-PC selection, variable-latency imem requests,
// and a one-entry skid buffer in front of the IF/ID register.
module fetch_stage #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [4:0]  HALT_OPCODE = 5'b00000
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus,
    output logic [1:0]    fsm_state
);
    // Handshakes: a fetch completes on any cycle with imem_req=1 and
    // imem_ack=1; imem_addr holds while imem_req=1 and no ack has arrived.
    // IF/ID transfers to decode on every edge where id_valid=0 or id_stall=0.

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_DRAIN = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t      state, state_nx;
    logic [15:0] pc, pc_nx;
    logic [15:0] req_addr;
    logic        outstanding;
    logic        run;
    logic        hold_valid;
    logic [15:0] hold_instr;
    logic [15:0] hold_pc;
    logic        accept;
    logic        advance;
    logic        is_halt;

    assign fsm_state = state;

    // run stays low for the first cycle after reset so a late ack from a
    // request killed by reset arrives with imem_req=0 and is flagged.
    always_comb begin
        bus.imem_req = 1'b0;
        if (run) begin
            case (state)
                S_FETCH: bus.imem_req = outstanding || !hold_valid;
                S_DRAIN: bus.imem_req = 1'b1;
                default: bus.imem_req = 1'b0;
            endcase
        end
    end

    assign bus.imem_addr = outstanding ? req_addr : pc;

    assign accept  = (state == S_FETCH) && bus.imem_req && bus.imem_ack &&
                     !bus.redirect_valid;
    assign is_halt = (bus.imem_rdata[15:11] == HALT_OPCODE);
    assign advance = !bus.id_valid || !bus.id_stall;

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        if (bus.redirect_valid) begin
            pc_nx    = {bus.redirect_pc[15:1], 1'b0};
            state_nx = (bus.imem_req && !bus.imem_ack) ? S_DRAIN : S_FETCH;
        end else begin
            case (state)
                S_FETCH: begin
                    if (accept) begin
                        if (is_halt) state_nx = S_HALT;
                        else         pc_nx    = pc + 16'd2;
                    end
                end
                S_DRAIN: begin
                    if (bus.imem_ack) state_nx = S_FETCH;
                end
                default: state_nx = S_HALT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_FETCH;
            pc            <= RESET_PC;
            req_addr      <= RESET_PC;
            outstanding   <= 1'b0;
            run           <= 1'b0;
            hold_valid    <= 1'b0;
            hold_instr    <= 16'h0000;
            hold_pc       <= 16'h0000;
            bus.id_valid  <= 1'b0;
            bus.id_instr  <= 16'h0000;
            bus.id_pc     <= 16'h0000;
            bus.id_pc_inc <= 16'h0000;
            bus.err       <= 1'b0;
        end else begin
            state       <= state_nx;
            pc          <= pc_nx;
            run         <= 1'b1;
            outstanding <= bus.imem_req && !bus.imem_ack;
            if (bus.imem_req) req_addr <= bus.imem_addr;

            if ((bus.redirect_valid && bus.redirect_pc[0]) ||
                (bus.imem_ack && !bus.imem_req))
                bus.err <= 1'b1;

            if (bus.redirect_valid) begin
                bus.id_valid <= 1'b0;
                hold_valid   <= 1'b0;
            end else if (advance) begin
                if (hold_valid) begin
                    bus.id_valid  <= 1'b1;
                    bus.id_instr  <= hold_instr;
                    bus.id_pc     <= hold_pc;
                    bus.id_pc_inc <= hold_pc + 16'd2;
                    hold_valid    <= 1'b0;
                end else if (accept) begin
                    bus.id_valid  <= 1'b1;
                    bus.id_instr  <= bus.imem_rdata;
                    bus.id_pc     <= bus.imem_addr;
                    bus.id_pc_inc <= bus.imem_addr + 16'd2;
                end else begin
                    bus.id_valid  <= 1'b0;
                end
            end else if (accept) begin
                // Only one request is ever in flight and none is issued while
                // the buffer is full, so this slot is always free here.
                hold_valid <= 1'b1;
                hold_instr <= bus.imem_rdata;
                hold_pc    <= bus.imem_addr;
            end
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: zero-wait and multi-cycle memory, stalls,
// redirects, HALT, error flag and asynchronous reset.
module tb_fetch_stage;
    logic        clk;
    logic        rst;
    logic [1:0]  fsm_state;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        spur_ack;
    int          lat;
    int          wait_cnt;
    logic [15:0] mem [0:255];
    int          n_checks;
    int          n_fail;

    fetch_stage_if bus();

    assign bus.imem_ack   = mem_ack | spur_ack;
    assign bus.imem_rdata = mem_rdata;

    fetch_stage #(.RESET_PC(16'h0000), .HALT_OPCODE(5'b00000)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory responder: acks after lat wait cycles (lat=0 acks in the request cycle).
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 16'h0000;
        wait_cnt  = 0;
    end
    always @(negedge clk) begin
        if (bus.imem_req) begin
            if (wait_cnt == lat) begin
                mem_ack   <= 1'b1;
                mem_rdata <= mem[bus.imem_addr[8:1]];
                wait_cnt  <= 0;
            end else begin
                mem_ack  <= 1'b0;
                wait_cnt <= wait_cnt + 1;
            end
        end else begin
            mem_ack  <= 1'b0;
            wait_cnt <= 0;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_id(input string tag, input logic [15:0] pc, input logic [15:0] instr);
        check({tag, "_valid"}, {15'd0, bus.id_valid}, 16'd1);
        check({tag, "_pc"}, bus.id_pc, pc);
        check({tag, "_pc_inc"}, bus.id_pc_inc, pc + 16'd2);
        check({tag, "_instr"}, bus.id_instr, instr);
    endtask

    task automatic do_reset;
        rst                = 1'b0;
        bus.id_stall       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 16'h0000;
        spur_ack           = 1'b0;
        step(2);
        rst = 1'b1;
        step(1);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 256; i++) mem[i] = 16'hA000 + 16'(i);
        mem[0] = 16'h1111;
        mem[1] = 16'h2222;
        mem[2] = 16'h3333;
        lat    = 0;
        rst                = 1'b0;
        bus.id_stall       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 16'h0000;
        spur_ack           = 1'b0;

        // 1: reset values, then zero-wait streaming
        step(2);
        check("rst_req", {15'd0, bus.imem_req}, 16'd0);
        check("rst_valid", {15'd0, bus.id_valid}, 16'd0);
        check("rst_pc", bus.id_pc, 16'h0000);
        check("rst_pc_inc", bus.id_pc_inc, 16'h0000);
        check("rst_instr", bus.id_instr, 16'h0000);
        check("rst_err", {15'd0, bus.err}, 16'd0);
        rst = 1'b1;
        step(1);
        check("t1_req", {15'd0, bus.imem_req}, 16'd1);
        check("t1_addr", bus.imem_addr, 16'h0000);
        step(1); check_id("t1_a", 16'h0000, 16'h1111);
        step(1); check_id("t1_b", 16'h0002, 16'h2222);
        step(1); check_id("t1_c", 16'h0004, 16'h3333);
        check("t1_err", {15'd0, bus.err}, 16'd0);

        // 2: decode stall for three edges, skid buffer holds one entry
        do_reset;
        step(1); check_id("t2_a", 16'h0000, 16'h1111);
        bus.id_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check_id("t2_hold", 16'h0000, 16'h1111);
            if (i > 0) check("t2_req_full", {15'd0, bus.imem_req}, 16'd0);
        end
        bus.id_stall = 1'b0;
        step(1); check_id("t2_b", 16'h0002, 16'h2222);
        check("t2_req_again", {15'd0, bus.imem_req}, 16'd1);
        check("t2_addr", bus.imem_addr, 16'h0004);
        step(1); check_id("t2_c", 16'h0004, 16'h3333);
        step(1); check_id("t2_d", 16'h0006, 16'hA003);

        // 3: 3-wait memory, redirect orphans the request to 0x0004
        do_reset;
        lat = 3;
        step(4); check_id("t3_a", 16'h0000, 16'h1111);
        step(4); check_id("t3_b", 16'h0002, 16'h2222);
        step(1);
        check("t3_addr0", bus.imem_addr, 16'h0004);
        check("t3_req0", {15'd0, bus.imem_req}, 16'd1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'h0040;
        step(1);
        bus.redirect_valid = 1'b0;
        check("t3_drain", {14'd0, fsm_state}, 16'd1);
        check("t3_addr1", bus.imem_addr, 16'h0004);
        check("t3_req1", {15'd0, bus.imem_req}, 16'd1);
        check("t3_valid1", {15'd0, bus.id_valid}, 16'd0);
        step(1);
        check("t3_addr2", bus.imem_addr, 16'h0004);
        step(1);
        check("t3_fetch", {14'd0, fsm_state}, 16'd0);
        check("t3_addr3", bus.imem_addr, 16'h0040);
        check("t3_valid3", {15'd0, bus.id_valid}, 16'd0);
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("t3_no_stale", {15'd0, bus.id_valid}, 16'd0);
        end
        step(1); check_id("t3_tgt", 16'h0040, 16'hA020);
        lat = 0;

        // 4: HALT at 0x0006, then redirect out of HALT
        mem[3] = 16'h0000;
        do_reset;
        step(3); check_id("t4_c", 16'h0004, 16'h3333);
        step(1); check_id("t4_halt", 16'h0006, 16'h0000);
        check("t4_state", {14'd0, fsm_state}, 16'd2);
        check("t4_req", {15'd0, bus.imem_req}, 16'd0);
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("t4_idle_req", {15'd0, bus.imem_req}, 16'd0);
            check("t4_idle_valid", {15'd0, bus.id_valid}, 16'd0);
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'h0020;
        step(1);
        bus.redirect_valid = 1'b0;
        check("t4_resume_state", {14'd0, fsm_state}, 16'd0);
        check("t4_resume_req", {15'd0, bus.imem_req}, 16'd1);
        check("t4_resume_addr", bus.imem_addr, 16'h0020);
        step(1); check_id("t4_resume", 16'h0020, 16'hA010);
        mem[3] = 16'hA003;

        // 5a: misaligned redirect target
        do_reset;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'h0013;
        step(1);
        bus.redirect_valid = 1'b0;
        check("t5_err", {15'd0, bus.err}, 16'd1);
        check("t5_addr", bus.imem_addr, 16'h0012);
        check("t5_valid", {15'd0, bus.id_valid}, 16'd0);
        step(1); check_id("t5_tgt", 16'h0012, 16'hA009);
        step(2);
        check("t5_err_sticky", {15'd0, bus.err}, 16'd1);

        // 5b: ack while no request is pending
        do_reset;
        check("t5b_err0", {15'd0, bus.err}, 16'd0);
        step(1); check_id("t5b_a", 16'h0000, 16'h1111);
        bus.id_stall = 1'b1;
        step(1);
        check("t5b_req", {15'd0, bus.imem_req}, 16'd0);
        spur_ack = 1'b1;
        step(1);
        spur_ack = 1'b0;
        check("t5b_err", {15'd0, bus.err}, 16'd1);
        check_id("t5b_keep", 16'h0000, 16'h1111);
        bus.id_stall = 1'b0;
        step(1); check_id("t5b_b", 16'h0002, 16'h2222);
        step(1); check_id("t5b_c", 16'h0004, 16'h3333);

        // 6: asynchronous reset in the middle of a 3-wait fetch
        do_reset;
        lat = 3;
        step(4); check_id("t6_a", 16'h0000, 16'h1111);
        bus.id_stall = 1'b1;
        step(1);
        check("t6_valid_pre", {15'd0, bus.id_valid}, 16'd1);
        check("t6_req_pre", {15'd0, bus.imem_req}, 16'd1);
        check("t6_addr_pre", bus.imem_addr, 16'h0002);
        #1 rst = 1'b0;
        #1;
        check("t6_valid_async", {15'd0, bus.id_valid}, 16'd0);
        check("t6_req_async", {15'd0, bus.imem_req}, 16'd0);
        check("t6_state_async", {14'd0, fsm_state}, 16'd0);
        bus.id_stall = 1'b0;
        rst = 1'b1;
        step(1);
        check("t6_req_post", {15'd0, bus.imem_req}, 16'd1);
        check("t6_addr_post", bus.imem_addr, 16'h0000);
        check("t6_err_post", {15'd0, bus.err}, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch front end of the pipelined processor. Sits directly upstream of decode.
- Owns the PC and the next-PC selection (sequential +2, or a redirect from execute).
- Drives a variable-latency instruction-memory request/ack interface.
- Delivers instructions into the IF/ID pipeline register through a one-entry skid buffer, so decode stalls never lose or duplicate an instruction.
- Stops fetching after a HALT instruction.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.
HALT_OPCODE, 5'b00000, value of instr[15:11] that identifies HALT.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  reset: asynchronous, active-low (0 = in reset).
imem_req  output  1  fetch request valid.
imem_addr  output  16  fetch address; stable while imem_req=1 and no ack yet.
imem_ack  input  1  response valid; may arrive in the same cycle as imem_req.
imem_rdata  input  16  instruction, valid when imem_ack=1.
redirect_valid  input  1  execute-stage branch/jump taken.
redirect_pc  input  16  redirect target.
id_stall  input  1  decode cannot accept; hold IF/ID.
id_valid  output  1  IF/ID holds a valid instruction.
id_instr  output  16  IF/ID instruction.
id_pc  output  16  address of id_instr.
id_pc_inc  output  16  id_pc + 2.
err  output  1  sticky protocol/alignment error.

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_PC, state=FETCH, no outstanding request, hold buffer empty.
  - id_valid=0, id_instr=0, id_pc=0, id_pc_inc=0, err=0.
  - imem_req=0 while rst=0.
- State machine (FETCH, DRAIN, HALT):
  - FETCH: issue a request at pc when no request is outstanding and the hold buffer is empty. Keep imem_req=1 until imem_ack.
  - DRAIN: an outstanding request was orphaned by a redirect. Keep imem_req=1 with the old address until ack, discard the data, then go to FETCH.
  - HALT: imem_req=0. Leave only on redirect_valid (to FETCH) or reset.
- Accepted ack (FETCH, imem_ack=1, no redirect in the same cycle):
  - The instruction and its pc form an entry.
  - pc <= pc+2, wrapping modulo 2^16.
  - If instr[15:11]==HALT_OPCODE: pc holds its value and the next state is HALT. The HALT entry is still delivered to decode.
- IF/ID advances when id_valid=0 or id_stall=0. On advance, in priority order:
  - hold buffer entry if present (buffer empties);
  - otherwise the entry accepted this cycle;
  - otherwise id_valid<=0.
- If IF/ID does not advance and an entry is accepted, the entry goes to the hold buffer.
  - At most one outstanding request plus an empty-buffer issue rule guarantees the buffer never overflows.
- id_pc_inc = id_pc + 2, registered with id_pc.
- Latency and throughput:
  - Zero-wait memory (ack in the request cycle): id_valid rises one cycle after the request.
  - Sustained 1 instruction/cycle with no stalls.
- redirect_valid=1 has priority over id_stall, ack and halt. Next edge:
  - id_valid<=0, hold buffer cleared.
  - pc <= {redirect_pc[15:1],1'b0}.
  - Outstanding request without ack this cycle: state<=DRAIN.
  - Ack in the same cycle: data discarded, state<=FETCH, new request issued the next cycle.
  - Redirect during DRAIN: update pc, stay in DRAIN.
- err (sticky until reset):
  - set when redirect_valid=1 and redirect_pc[0]=1;
  - set when imem_ack=1 while imem_req=0. The spurious ack is ignored.
- Reset asserted mid-request: all state clears immediately. After release, fetch restarts at RESET_PC and any late ack is ignored and flagged as err.

Test Plan:
1. Zero-wait memory with instrs 0x1111/0x2222/0x3333 at 0x0/0x2/0x4, release reset → id_pc = 0x0, 0x2, 0x4 in consecutive cycles; id_pc_inc = 0x2, 0x4, 0x6; imem_req=0 during reset.
2. id_stall=1 for 3 cycles while fetching from 0x0 → id_instr holds 0x1111; exactly one further entry (0x2) buffered; imem_req=0 while buffer full; after release, 0x2 and 0x4 are delivered in order with no loss or duplicate.
3. 3-cycle memory latency, redirect_valid=1 with redirect_pc=0x0040 one cycle after request to 0x0004 → imem_addr stays 0x0004 until ack; stale data dropped; next id_pc=0x0040 with id_valid=1; no id_pc=0x0004 ever.
4. HALT (0x0000) at 0x0006 → delivered with id_pc=0x0006; imem_req=0 for 10 cycles; redirect to 0x0020 resumes fetch at 0x0020.
5. redirect_pc=0x0013 → err=1 and stays 1; fetch proceeds at 0x0012. Separate run: imem_ack=1 while imem_req=0 → err=1, no id_valid change.
6. rst=0 asynchronously mid-wait (3-cycle memory) → id_valid=0 and imem_req=0 immediately, without a clock edge; after release the first imem_addr is RESET_PC.
